// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-input round-robin arbiter feeding a one-entry registered output stage.
// Define RR_MUX_ARB_LAST_EN to add in_last/out_last and packet locking.
module rr_mux_arb #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
`ifdef RR_MUX_ARB_LAST_EN
  ,
  input  logic [N-1:0]       in_last,
  output logic               out_last
`endif
);

  localparam logic [SEL_W:0]   N_CNT    = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N-1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0] chan_data [N];
  logic [N-1:0]     elig;
  logic [2*N-1:0]   rot;
  logic [SEL_W-1:0] off, grant_idx, grant_nxt;
  logic [SEL_W:0]   sum;
  logic             grant_found, load_en, accept;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = accept && (grant_idx == SEL_W'(gi));
    end
  endgenerate

`ifdef RR_MUX_ARB_LAST_EN
  logic lock_q, lock_d;
  logic last_q, last_d;

  // The locked channel is always the one that supplied the last accepted beat.
  always_comb begin
    elig = in_valid;
    if (lock_q) begin
      elig          = '0;
      elig[sel_q]   = in_valid[sel_q];
    end
  end
`else
  assign elig = in_valid;
`endif

  // Rotate eligibility so ptr sits at bit 0, then take the lowest set offset.
  always_comb begin
    rot         = {elig, elig} >> ptr_q;
    grant_found = |elig;
    off         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    sum       = {1'b0, ptr_q} + {1'b0, off};
    grant_idx = (sum >= N_CNT) ? SEL_W'(sum - N_CNT) : sum[SEL_W-1:0];
    grant_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
  end

  assign load_en = !valid_q || out_ready;
  assign accept  = load_en && grant_found && !rst;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef RR_MUX_ARB_LAST_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    if (accept) begin
      data_d  = chan_data[grant_idx];
      valid_d = 1'b1;
      sel_d   = grant_idx;
`ifdef RR_MUX_ARB_LAST_EN
      last_d  = in_last[grant_idx];
      lock_d  = !in_last[grant_idx];
      if (in_last[grant_idx]) ptr_d = grant_nxt;
`else
      ptr_d   = grant_nxt;
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef RR_MUX_ARB_LAST_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef RR_MUX_ARB_LAST_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;
`ifdef RR_MUX_ARB_LAST_EN
  assign out_last  = last_q;
`endif

endmodule
